wb_burst_reader: RTL and testbench
==================================

# wb_burst_reader

Wishbone master that fetches a contiguous block of 32-bit words from a Wishbone memory slave (the on-chip BlockRAM) and delivers them in order on a valid/ready stream. It sits directly upstream of the memory, on the master side of the bus, and feeds consumers such as the display path. Transfers use incrementing-address bursts, issued only when the internal FIFO can absorb a whole burst, so the bus is never stalled by a slow consumer.

## Interface
- ADR_WIDTH, 32: Wishbone byte-address width.
- WORDS, 2048: number of 32-bit words per transfer (≥1).
- BURST_LEN, 16: maximum beats per burst (power of two, ≥2).
- FIFO_DEPTH, 32: stream FIFO depth (power of two, ≥ BURST_LEN).
- clk  in  1  single clock for bus and stream.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- base_adr  in  ADR_WIDTH  byte start address, sampled on start; bits [1:0] ignored (forced 0).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse on the last bus ack.
- wb_cyc, wb_stb  out  1  bus cycle / strobe.
- wb_we  out  1  constant 0.
- wb_sel  out  4  constant 4'b1111.
- wb_adr  out  ADR_WIDTH  byte address, word aligned.
- wb_cti  out  3  cycle type identifier.
- wb_bte  out  2  constant 2'b00 (linear).
- wb_dat_sm  in  32  read data from slave.
- wb_ack  in  1  slave acknowledge.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.

## Operation
- FSM states: IDLE, WAIT_ROOM, BURST.
- IDLE: start=1 → latch base_adr into adr register, remaining = WORDS → WAIT_ROOM. start outside IDLE is ignored.
- WAIT_ROOM: beats = min(BURST_LEN, remaining); when FIFO free entries ≥ beats → BURST with beat counter = beats.
- BURST: wb_cyc = wb_stb = 1, wb_adr = adr register. Each cycle with wb_ack: push wb_dat_sm into FIFO, adr += 4, remaining −= 1, beat counter −= 1.
- wb_cti = 3'b010 on every beat except the last of the burst, which carries 3'b111.
- After the last beat's ack: remaining = 0 → IDLE with a done pulse; otherwise → WAIT_ROOM. wb_cyc/wb_stb drop for at least one cycle between bursts.
- Final burst is shorter when WORDS is not a multiple of BURST_LEN, e.g. WORDS=20, BURST_LEN=16 gives bursts of 16 then 4.
- Address arithmetic is modulo 2^ADR_WIDTH; wrap past the top is silent.
- FIFO: push on ack, pop on out_valid & out_ready. Simultaneous push and pop is legal, including at full. Overflow is impossible by the room check, because free space is counted only between bursts and no words are in flight then.
- Output reset values: wb_cyc=0, wb_stb=0, wb_cti=0, wb_adr=0, busy=0, done=0, out_valid=0, out_data=0.
- Reset mid-burst drops wb_cyc/wb_stb immediately (asynchronously), empties the FIFO and returns to IDLE.

## Timing
- start at cycle 0 → busy=1 and state WAIT_ROOM at cycle 1 → wb_cyc/wb_stb=1 at cycle 2 when room is available.
- The slave may insert wait states; wb_adr/wb_cti hold until ack. With a zero-wait slave, one beat per cycle.
- Pushed word is visible on out_data/out_valid the cycle after its ack (registered FIFO output).
- done coincides with the cycle after the final ack; busy falls the same cycle.

## Configuration
- WB_BURST_READER_BURST_EN defined: burst behaviour above.
- Undefined: classic cycles only. wb_cti=3'b000 always. Each word is its own cycle: after each ack, wb_stb/wb_cyc deassert for one cycle and the room check is for 1 entry. Data, ordering and done semantics are unchanged.

## Structure
- Package wb_pkg: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, BTE_LINEAR=2'b00, and the FSM state enum.
- Sub-module wb_rd_fifo: synchronous FIFO with an asynchronous active-low reset, providing a free-entry count, registered output and valid/ready pop.

## Test plan
- WORDS=32, BURST_LEN=16, base 0x100, zero-wait slave, out_ready=1 → two bursts of 16. Addresses run 0x100..0x17C. cti is 010 ×15 then 111. Data matches memory; done after 32 acks.
- WORDS=20 → bursts of 16 and 4; the 4th beat of the second burst has cti=111.
- out_ready=0 with FIFO_DEPTH=32, WORDS=64 → exactly 32 words fetched, then stalls in WAIT_ROOM. Releasing out_ready resumes and the stream stays in order with no loss.
- Slave inserts 2 wait states per beat → wb_adr/wb_cti stable during waits; exactly one FIFO push per ack.
- rst_n asserted at beat 5 of the first burst → wb_cyc=0 immediately, out_valid=0, busy=0. A new start then restarts from the new base.
- WB_BURST_READER_BURST_EN undefined, WORDS=4 → four classic cycles with cti=000 and stb low between them; same data as the burst build.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Wishbone cycle-type constants and burst reader FSM states
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ROOM,
        BURST
    } rd_state_t;

endpackage

// File: rtl/wb_rd_fifo.sv
// rtl/wb_rd_fifo.sv - read-data FIFO with free-entry count and valid/ready pop
module wb_rd_fifo #(
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] free
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          do_push;

    assign pop     = out_valid && out_ready;
    // A push at full is only accepted when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign free      = CW'(DEPTH) - count;

endmodule

// File: rtl/wb_burst_reader.sv
// rtl/wb_burst_reader.sv - Wishbone block reader feeding a valid/ready stream;
// WB_BURST_READER_BURST_EN selects incrementing bursts, otherwise classic single cycles
module wb_burst_reader
    import wb_pkg::*;
#(
    parameter int ADR_WIDTH  = 32,
    parameter int WORDS      = 2048,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADR_WIDTH-1:0] base_adr,
    output logic                 busy,
    output logic                 done,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [3:0]           wb_sel,
    output logic [ADR_WIDTH-1:0] wb_adr,
    output logic [2:0]           wb_cti,
    output logic [1:0]           wb_bte,
    input  logic [31:0]          wb_dat_sm,
    input  logic                 wb_ack,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int RW = $clog2(WORDS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rd_state_t            state;
    rd_state_t            state_nxt;
    logic [ADR_WIDTH-1:0] adr_q;
    logic [ADR_WIDTH-1:0] adr_nxt;
    logic [RW-1:0]        remaining_q;
    logic [RW-1:0]        remaining_nxt;
    logic [BW-1:0]        beat_q;
    logic [BW-1:0]        beat_nxt;
    logic [BW-1:0]        beats_need;
    logic                 done_q;
    logic                 done_nxt;
    logic [CW-1:0]        fifo_free;
    logic                 ack_beat;

    assign ack_beat = (state == BURST) && wb_ack;

`ifdef WB_BURST_READER_BURST_EN
    always_comb begin
        beats_need = BW'(BURST_LEN);
        if (32'(remaining_q) < BURST_LEN) begin
            beats_need = BW'(remaining_q);
        end
    end
`else
    assign beats_need = BW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            adr_q       <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            adr_q       <= adr_nxt;
            remaining_q <= remaining_nxt;
            beat_q      <= beat_nxt;
            done_q      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        adr_nxt       = adr_q;
        remaining_nxt = remaining_q;
        beat_nxt      = beat_q;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    adr_nxt       = base_adr & ~ADR_WIDTH'(3);
                    remaining_nxt = RW'(WORDS);
                    state_nxt     = WAIT_ROOM;
                end
            end
            // Room is judged only here, with nothing in flight, so a whole burst always fits.
            WAIT_ROOM: begin
                if (32'(fifo_free) >= 32'(beats_need)) begin
                    beat_nxt  = beats_need;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (wb_ack) begin
                    adr_nxt       = adr_q + ADR_WIDTH'(4);
                    remaining_nxt = remaining_q - RW'(1);
                    beat_nxt      = beat_q - BW'(1);
                    if (beat_q == BW'(1)) begin
                        if (remaining_q == RW'(1)) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = WAIT_ROOM;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wb_cyc = (state == BURST);
    assign wb_stb = (state == BURST);
    assign wb_we  = 1'b0;
    assign wb_sel = 4'b1111;
    assign wb_bte = BTE_LINEAR;
    assign wb_adr = adr_q;
    assign busy   = (state != IDLE);
    assign done   = done_q;

`ifdef WB_BURST_READER_BURST_EN
    assign wb_cti = (state != BURST)    ? CTI_CLASSIC :
                    (beat_q == BW'(1))  ? CTI_EOB     : CTI_INCR;
`else
    assign wb_cti = CTI_CLASSIC;
`endif

    wb_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ack_beat),
        .push_data (wb_dat_sm),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .free      (fifo_free)
    );

endmodule

// File: tb/tb_wb_burst_reader.sv
// tb/tb_wb_burst_reader.sv - self-checking bench for wb_burst_reader
module tb_wb_burst_reader;

    localparam int WORDS = 40;
    localparam int BL    = 16;
    localparam int DEPTH = 32;
`ifdef WB_BURST_READER_BURST_EN
    localparam int EXP_BURSTS = 3;
    localparam int EXP_EOB    = 3;
`else
    localparam int EXP_BURSTS = WORDS;
    localparam int EXP_EOB    = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_adr;
    logic        busy;
    logic        done;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_sm;
    logic        wb_ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    wb_burst_reader #(
        .ADR_WIDTH  (32),
        .WORDS      (WORDS),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_adr  (base_adr),
        .busy      (busy),
        .done      (done),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_adr    (wb_adr),
        .wb_cti    (wb_cti),
        .wb_bte    (wb_bte),
        .wb_dat_sm (wb_dat_sm),
        .wb_ack    (wb_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave: combinational ack after a programmable number of wait states.
    int wait_states = 0;
    int wait_cnt    = 0;
    assign wb_ack    = wb_cyc && wb_stb && (wait_cnt == wait_states);
    assign wb_dat_sm = mem_fn(wb_adr);
    always @(posedge clk) begin
        if (wb_cyc && wb_stb && !wb_ack) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic bit last_of_burst(input int k);
`ifdef WB_BURST_READER_BURST_EN
        return ((k % BL) == BL - 1) || (k == WORDS - 1);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [2:0] exp_cti(input int k);
`ifdef WB_BURST_READER_BURST_EN
        return last_of_burst(k) ? 3'b111 : 3'b010;
`else
        return 3'b000;
`endif
    endfunction

    function automatic int burst_need(input int k);
`ifdef WB_BURST_READER_BURST_EN
        return (WORDS - k < BL) ? WORDS - k : BL;
`else
        return 1;
`endif
    endfunction

    // Transfer-level model: word k of a transfer lives at base+4k and must leave the stream in order.
    logic [31:0] m_fifo[$];
    bit          m_active  = 0;
    bit          m_done_due = 0;
    bit          m_gap_due  = 0;
    bit          prev_stb   = 0;
    bit          done_seen  = 0;
    logic [31:0] m_base     = '0;
    logic [31:0] first_pop  = '0;
    logic [31:0] last_ack_adr = '0;
    int          n_acks = 0;
    int          n_pops = 0;
    int          n_rise = 0;
    int          n_eob  = 0;

    always @(negedge clk) begin
        bit was_active;
        if (!rst_n) begin
            chk("rst_cyc", 32'(wb_cyc), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_done", 32'(done), 0);
            m_fifo.delete();
            m_active   = 0;
            m_done_due = 0;
            m_gap_due  = 0;
            prev_stb   = 0;
        end else begin
            was_active = m_active;
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done_due));
            if (done) done_seen = 1;
            m_done_due = 0;
            chk("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
            if (m_gap_due) chk("gap_between", 32'(wb_cyc), 0);
            m_gap_due = 0;
            chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
            if (out_valid && out_ready && m_fifo.size() != 0) begin
                if (n_pops == 0) first_pop = out_data;
                chk("out_data", out_data, m_fifo.pop_front());
                n_pops++;
            end
            if (wb_stb) begin
                chk("stb_in_transfer", 32'(m_active && n_acks < WORDS), 1);
                chk("adr", wb_adr, m_base + 32'(4 * n_acks));
                chk("cti", 32'(wb_cti), 32'(exp_cti(n_acks)));
                if (!prev_stb) begin
                    n_rise++;
                    chk("room", 32'(m_fifo.size() + burst_need(n_acks) <= DEPTH), 1);
                end
                if (wb_ack) begin
                    if (wb_cti == 3'b111) n_eob++;
                    last_ack_adr = wb_adr;
                    m_fifo.push_back(mem_fn(m_base + 32'(4 * n_acks)));
                    if (last_of_burst(n_acks)) m_gap_due = 1;
                    n_acks++;
                    if (n_acks == WORDS) begin
                        m_done_due = 1;
                        m_active   = 0;
                    end
                end
            end
            prev_stb = wb_stb;
            if (start && !was_active) begin
                m_active  = 1;
                m_base    = base_adr & ~32'd3;
                n_acks    = 0;
                n_pops    = 0;
                n_rise    = 0;
                n_eob     = 0;
                done_seen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a);
        start    = 1'b1;
        base_adr = a;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input bit throttle);
        int iter;
        iter = 0;
        while (!(done_seen && m_fifo.size() == 0 && !out_valid) && iter < 3000) begin
            out_ready = throttle ? ((iter % 3) != 2) : 1'b1;
            tick();
            iter++;
        end
        out_ready = 1'b1;
        chk("run_complete", 32'(done_seen), 1);
        chk("pop_count", n_pops, WORDS);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        base_adr  = '0;
        out_ready = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) tick();
        chk("reset_cyc", 32'(wb_cyc), 0);
        chk("reset_stb", 32'(wb_stb), 0);
        chk("reset_adr", wb_adr, 0);
        chk("reset_cti", 32'(wb_cti), 0);
        chk("reset_out_data", out_data, 0);
        chk("const_we", 32'(wb_we), 0);
        chk("const_sel", 32'(wb_sel), 32'hF);
        chk("const_bte", 32'(wb_bte), 0);
        rst_n = 1'b1;
        tick();

        // Run A: zero-wait slave, free-running consumer, plus an ignored start.
        do_start(32'h100);
        chk("lat_busy", 32'(busy), 1);
        chk("lat_cyc1", 32'(wb_cyc), 0);
        tick();
        chk("lat_cyc2", 32'(wb_cyc), 1);
        chk("first_adr", wb_adr, 32'h100);
        do_start(32'h4000);
        wait_done(1'b0);
        chk("a_first_word", first_pop, 32'h0100FEFF);
        chk("a_last_adr", last_ack_adr, 32'h19C);
        chk("a_bursts", n_rise, EXP_BURSTS);
        chk("a_eob", n_eob, EXP_EOB);

        // Run B: consumer stalled until the FIFO is full, then throttled.
        out_ready = 1'b0;
        do_start(32'h2000);
        out_ready = 1'b0;
        repeat (150) tick();
        chk("stall_acks", n_acks, DEPTH);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_cyc", 32'(wb_cyc), 0);
        chk("stall_head", out_data, 32'h2000DFFF);
        wait_done(1'b1);

        // Run C: two wait states per beat, unaligned base wrapping past the top.
        wait_states = 2;
        do_start(32'hFFFF_FFE3);
        wait_done(1'b0);
        chk("c_last_adr_wrap", last_ack_adr, 32'h7C);
        chk("c_first_word", first_pop, 32'hFFE0001F);
        wait_states = 0;

        // Run D: reset during the fifth beat, then a fresh transfer.
        do_start(32'h300);
        for (int i = 0; i < 50 && n_acks < 4; i++) tick();
        chk("d_acks_before_rst", n_acks, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("d_async_cyc", 32'(wb_cyc), 0);
        chk("d_async_stb", 32'(wb_stb), 0);
        chk("d_async_valid", 32'(out_valid), 0);
        chk("d_async_busy", 32'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_start(32'h800);
        wait_done(1'b1);
        chk("d_first_word", first_pop, 32'h0800F7FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
